// File: rtl/yarvi_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : yarvi_operand_stage
//  Purpose  : Register-read / operand-forwarding stage in front of the ALU.
//             Holds the architectural register file and a load scoreboard.
//             Resolves operands from the register file, the ALU result of
//             the departing instruction, or returning load data. Captures
//             op1/op2 and control into a single output slot that the ALU
//             consumes. Decode is stalled on load-use and on a write to a
//             register that still has a load in flight.
//
//  Ports    : clock, reset_n           - clock, async active-low reset
//             id_*                      - decoded instruction + handshake
//             ex_*                      - output slot + ALU handshake/result
//             mem_*                     - load data return (write port 2)
//
//  Revision : 1.0 - initial release
// ============================================================================
module yarvi_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_wen,
    input  logic            id_load,
    input  logic            id_use_imm,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_ctl,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic            ex_load,
    output logic [4:0]      ex_ctl,
    input  logic [XLEN-1:0] ex_result,

    input  logic            mem_wen,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pending;

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_op1;
    logic [XLEN-1:0] r_ex_op2;
    logic [4:0]      r_ex_rd;
    logic            r_ex_wen;
    logic            r_ex_load;
    logic [4:0]      r_ex_ctl;

    // ------------------------------------------------------------------
    // Handshake and write-port qualifiers
    // ------------------------------------------------------------------
    logic w_ex_fire;
    logic w_id_fire;
    logic w_free;
    logic w_alu_wr;     // departing ALU instruction writes the register file
    logic w_ld_set;     // departing load marks its rd pending
    logic w_mem_wr;     // load return writes the register file

    assign w_ex_fire = r_ex_valid & ex_ready;
    assign w_free    = ~r_ex_valid | w_ex_fire;
    assign w_alu_wr  = w_ex_fire & r_ex_wen & ~r_ex_load & (r_ex_rd != 5'd0);
    assign w_ld_set  = w_ex_fire & r_ex_load & r_ex_wen & (r_ex_rd != 5'd0);
    assign w_mem_wr  = mem_wen & (mem_rd != 5'd0);

    // ------------------------------------------------------------------
    // Operand resolution: x0, then ALU bypass, then load bypass, then RF.
    // The two bypass sources can never name the same register, so the
    // ordering between them only matters for readability.
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] f_resolve(input logic [4:0] s);
        logic [XLEN-1:0] v;
        if (s == 5'd0)
            v = '0;
        else if (w_alu_wr && (r_ex_rd == s))
            v = ex_result;
        else if (mem_wen && (mem_rd == s))
            v = mem_data;
        else
            v = r_regs[s];
        return v;
    endfunction

    // A source is unavailable while its load is outstanding (unless the data
    // arrives this very cycle) or while the load that produces it is leaving
    // the slot right now (its data cannot be back before next cycle).
    function automatic logic f_src_hazard(input logic [4:0] s);
        logic still_pending;
        logic load_leaving;
        still_pending = r_pending[s] & ~(mem_wen & (mem_rd == s));
        load_leaving  = w_ex_fire & r_ex_load & r_ex_wen & (r_ex_rd == s);
        return (s != 5'd0) & (still_pending | load_leaving);
    endfunction

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_rs1_haz;
    logic            w_rs2_haz;
    logic            w_waw_haz;
    logic            w_hazard;

    assign w_op1 = f_resolve(id_rs1);
    assign w_op2 = id_use_imm ? id_imm : f_resolve(id_rs2);

    assign w_rs1_haz = f_src_hazard(id_rs1);
    assign w_rs2_haz = ~id_use_imm & f_src_hazard(id_rs2);

    // Writing a register that still awaits load data would let the late load
    // return clobber the newer value, and could also put both write ports on
    // the same register in one cycle. Hold the writer until the load is back.
    assign w_waw_haz = id_wen & (id_rd != 5'd0)
                     & (r_pending[id_rd] | (w_ex_fire & r_ex_load & (r_ex_rd == id_rd)))
                     & ~(mem_wen & (mem_rd == id_rd));

    assign w_hazard  = w_rs1_haz | w_rs2_haz | w_waw_haz;
    assign id_ready  = w_free & ~w_hazard;
    assign w_id_fire = id_valid & id_ready;

    // ------------------------------------------------------------------
    // Register file (two write ports: ALU and load return)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_alu_wr) r_regs[r_ex_rd] <= ex_result;
            if (w_mem_wr) r_regs[mem_rd]  <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Load scoreboard. A set on the same register as a clear wins, since the
    // set belongs to a newer load.
    // ------------------------------------------------------------------
    logic [NREG-1:0] w_sb_set;
    logic [NREG-1:0] w_sb_clr;

    assign w_sb_set = w_ld_set ? (NREG'(1) << r_ex_rd) : '0;
    assign w_sb_clr = mem_wen  ? (NREG'(1) << mem_rd)  : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_sb_clr) | w_sb_set;
        end
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid <= 1'b0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_rd    <= '0;
            r_ex_wen   <= 1'b0;
            r_ex_load  <= 1'b0;
            r_ex_ctl   <= '0;
        end else if (w_id_fire) begin
            r_ex_valid <= 1'b1;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
            r_ex_rd    <= id_rd;
            r_ex_wen   <= id_wen;
            r_ex_load  <= id_load;
            r_ex_ctl   <= id_ctl;
        end else if (w_ex_fire) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_op1   = r_ex_op1;
    assign ex_op2   = r_ex_op2;
    assign ex_rd    = r_ex_rd;
    assign ex_wen   = r_ex_wen;
    assign ex_load  = r_ex_load;
    assign ex_ctl   = r_ex_ctl;

endmodule
`default_nettype wire

// File: tb/tb_yarvi_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yarvi_operand_stage
//  Purpose  : Self-checking bench for yarvi_operand_stage. A behavioural
//             model (register array, pending bits, one-entry slot) predicts
//             id_ready and the slot contents every cycle; directed sequences
//             add literal expectations; a random phase follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_yarvi_operand_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid, id_wen, id_load, id_use_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_ctl;
    logic [31:0] id_imm;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic        mem_wen;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;

    logic        id_ready, ex_valid, ex_wen, ex_load;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  ex_rd, ex_ctl;

    always #5 clock = ~clock;

    yarvi_operand_stage #(.XLEN(32), .NREG(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wen(id_wen), .id_load(id_load), .id_use_imm(id_use_imm),
        .id_imm(id_imm), .id_ctl(id_ctl),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
        .ex_wen(ex_wen), .ex_load(ex_load), .ex_ctl(ex_ctl),
        .ex_result(ex_result),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data)
    );

    // ------------------------------------------------------------------
    // Behavioural model state
    // ------------------------------------------------------------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_valid, m_wen, m_load;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd, m_ctl;

    int          errors = 0;
    int          checks = 0;
    logic        last_ready;
    logic        alu_ovr = 1'b0;
    logic [31:0] alu_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_wen = 1'b0; m_load = 1'b0;
        m_op1 = '0; m_op2 = '0; m_rd = '0; m_ctl = '0;
        m_pend = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_wen = 1'b0; id_load = 1'b0; id_use_imm = 1'b0; id_imm = '0; id_ctl = '0;
        mem_wen = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic load, input logic useimm,
                         input logic [31:0] imm);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_wen = wen; id_load = load; id_use_imm = useimm; id_imm = imm;
        id_ctl = 5'($urandom_range(0, 31));
    endtask

    // One clock cycle. Called just after a falling edge with inputs driven.
    // Compares DUT outputs to the model, then advances the model to the
    // state that must hold after the next rising edge.
    task automatic do_cycle();
        logic [31:0] nregs [32];
        logic [31:0] npend;
        logic        fire, exp_ready, idfire;

        // The ALU's answer is defined by the bench from what the slot must hold.
        ex_result = alu_ovr ? alu_val : ((m_op1 + m_op2) ^ {27'd0, m_ctl});
        #1;
        last_ready = id_ready;

        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid) begin
            chk("ex_op1",  ex_op1, m_op1);
            chk("ex_op2",  ex_op2, m_op2);
            chk("ex_rd",   32'(ex_rd), 32'(m_rd));
            chk("ex_wen",  32'(ex_wen), 32'(m_wen));
            chk("ex_load", 32'(ex_load), 32'(m_load));
            chk("ex_ctl",  32'(ex_ctl), 32'(m_ctl));
        end

        // Architectural state as it will be after this edge.
        fire = m_valid & ex_ready;
        for (int i = 0; i < 32; i++) nregs[i] = m_regs[i];
        if (fire && m_wen && !m_load && m_rd != 5'd0) nregs[m_rd] = ex_result;
        if (mem_wen && mem_rd != 5'd0) nregs[mem_rd] = mem_data;
        npend = m_pend;
        if (mem_wen) npend[mem_rd] = 1'b0;
        if (fire && m_load && m_wen && m_rd != 5'd0) npend[m_rd] = 1'b1;

        // An instruction may go only if the slot will be free and none of the
        // registers it reads or writes will still be waiting on a load.
        exp_ready = (!m_valid || fire)
                 && !(id_rs1 != 5'd0 && npend[id_rs1])
                 && !(!id_use_imm && id_rs2 != 5'd0 && npend[id_rs2])
                 && !(id_wen && id_rd != 5'd0 && npend[id_rd]);
        chk("id_ready", 32'(id_ready), 32'(exp_ready));

        idfire = id_valid && exp_ready;
        for (int i = 0; i < 32; i++) m_regs[i] = nregs[i];
        m_pend = npend;
        if (idfire) begin
            m_valid = 1'b1;
            m_op1   = (id_rs1 == 5'd0) ? 32'd0 : nregs[id_rs1];
            m_op2   = id_use_imm ? id_imm : ((id_rs2 == 5'd0) ? 32'd0 : nregs[id_rs2]);
            m_rd    = id_rd;
            m_wen   = id_wen;
            m_load  = id_load;
            m_ctl   = id_ctl;
        end else if (fire) begin
            m_valid = 1'b0;
        end

        @(negedge clock);
        mem_wen = 1'b0;
        alu_ovr = 1'b0;
        if (id_valid && last_ready) id_valid = 1'b0;
    endtask

    task automatic random_cycle();
        int k;
        id_valid   = ($urandom_range(0, 9) < 7);
        id_rs1     = 5'($urandom_range(0, 7));
        id_rs2     = 5'($urandom_range(0, 7));
        id_rd      = 5'($urandom_range(0, 7));
        id_wen     = ($urandom_range(0, 3) != 0);
        id_load    = ($urandom_range(0, 3) == 0);
        if (id_load) id_wen = 1'b1;
        id_use_imm = $urandom_range(0, 1) == 1;
        id_imm     = $urandom;
        id_ctl     = 5'($urandom_range(0, 31));
        ex_ready   = ($urandom_range(0, 3) != 0);
        mem_wen    = 1'b0;
        if (m_pend != 0 && $urandom_range(0, 9) < 4) begin
            k = $urandom_range(0, 31);
            while (!m_pend[k]) k = (k + 1) % 32;
            mem_wen  = 1'b1;
            mem_rd   = 5'(k);
            mem_data = $urandom;
        end
        do_cycle();
    endtask

    initial begin
        logic [31:0] held_op1, held_op2;
        reset_n = 1'b0;
        ex_ready = 1'b1;
        ex_result = '0;
        idle();
        model_reset();

        // ---------------- Reset ----------------
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ex_valid_low", 32'(ex_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_op1",   ex_op1, 32'd0);
        chk("rst_ex_rd",    32'(ex_rd), 32'd0);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_cycle();
        chk("rst_read_x5", ex_op1, 32'd0);

        // ---------------- Back-to-back forwarding ----------------
        issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'h10);   // addi x1
        do_cycle();
        chk("fwd_addi_ready", 32'(last_ready), 32'd1);
        alu_ovr = 1'b1; alu_val = 32'h10;
        issue(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0);    // add x2,x1,x1
        do_cycle();
        chk("fwd_no_stall", 32'(last_ready), 32'd1);
        chk("fwd_op1", ex_op1, 32'h10);
        chk("fwd_op2", ex_op2, 32'h10);

        // ---------------- Load-use ----------------
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h100);  // load x3
        do_cycle();
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0);    // add x4,x3,x0
        do_cycle();
        chk("lu_stall_leaving", 32'(last_ready), 32'd0);
        do_cycle();
        chk("lu_stall_pending", 32'(last_ready), 32'd0);
        mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'hDEAD;
        do_cycle();
        chk("lu_release", 32'(last_ready), 32'd1);
        chk("lu_op1", ex_op1, 32'hDEAD);

        // ---------------- WAW on pending load ----------------
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h200);  // load x3
        do_cycle();
        idle();
        do_cycle();                                          // load leaves
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h7);    // addi x3
        do_cycle();
        chk("waw_stall0", 32'(last_ready), 32'd0);
        do_cycle();
        chk("waw_stall1", 32'(last_ready), 32'd0);
        mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'hBEEF;
        do_cycle();
        chk("waw_release", 32'(last_ready), 32'd1);
        idle();
        alu_ovr = 1'b1; alu_val = 32'h7;
        do_cycle();                                          // addi x3 writes 7
        issue(5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0);    // add x5,x3,x0
        do_cycle();
        chk("waw_read_x3", ex_op1, 32'h7);

        // ---------------- Backpressure ----------------
        held_op1 = 32'h7;
        held_op2 = 32'h0;
        ex_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk("bp_stall", 32'(last_ready), 32'd0);
            chk("bp_op1_hold", ex_op1, held_op1);
            chk("bp_op2_hold", ex_op2, held_op2);
        end
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(5'd1, 5'd2, 5'(10 + i), 1'b1, 1'b0, 1'b0, 32'd0);
            do_cycle();
            chk("bp_resume", 32'(last_ready), 32'd1);
        end

        // ---------------- x0 handling ----------------
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h55);   // addi x0
        do_cycle();
        alu_ovr = 1'b1; alu_val = 32'h55;
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0);    // add x7,x0,x0
        do_cycle();
        chk("x0_op1", ex_op1, 32'd0);
        chk("x0_op2", ex_op2, 32'd0);
        chk("x0_rd",  32'(ex_rd), 32'd7);

        // ---------------- Mid-operation reset ----------------
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h300);  // load x3
        do_cycle();
        idle();
        do_cycle();                                          // load leaves
        ex_ready = 1'b0;
        issue(5'd1, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);
        do_cycle();
        chk("mr_slot_full", 32'(ex_valid), 32'd1);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_ex_valid", 32'(ex_valid), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        ex_ready = 1'b1;
        issue(5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0);    // read x3
        do_cycle();
        chk("mr_no_stall", 32'(last_ready), 32'd1);

        // ---------------- Random phase ----------------
        for (int n = 0; n < 3000; n++) random_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/yarvi_operand_stage.md
Name: yarvi_operand_stage

Overview:
Register-read / operand-forwarding stage directly upstream of the ALU.
- Holds the architectural register file and a load scoreboard.
- Accepts decoded instructions and resolves operands from the register file, the ALU result of the departing instruction, or load-return data.
- Registers op1/op2 and control into a single output slot that the ALU consumes.
- Stalls decode on load-use and WAW-on-pending-load hazards.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (index width 5); x0 hardwired zero

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
id_valid  in  1  decoded instruction present
id_ready  out  1  stage accepts instruction this cycle
id_rs1  in  5  source 1 index
id_rs2  in  5  source 2 index
id_rd  in  5  destination index
id_wen  in  1  instruction writes rd
id_load  in  1  rd value comes from memory, not ALU
id_use_imm  in  1  op2 = id_imm, rs2 unused
id_imm  in  XLEN  immediate
id_ctl  in  5  {insn30, w, funct3}, passed through
ex_valid  out  1  output slot occupied
ex_ready  in  1  ALU consumes slot this cycle
ex_op1  out  XLEN  registered operand 1
ex_op2  out  XLEN  registered operand 2
ex_rd  out  5  registered rd
ex_wen  out  1  registered id_wen
ex_load  out  1  registered id_load
ex_ctl  out  5  registered id_ctl
ex_result  in  XLEN  combinational ALU result for the slot's instruction
mem_wen  in  1  load data return valid
mem_rd  in  5  load destination
mem_data  in  XLEN  load data

Behaviour:
- Reset (async, reset_n low): ex_valid=0; ex_op1/ex_op2/ex_rd/ex_ctl=0; ex_wen=ex_load=0; scoreboard all 0; all registers 0.
- ex_fire = ex_valid & ex_ready. id_fire = id_valid & id_ready.
- Slot free: free = !ex_valid | ex_fire.
- Register-file writes at the clock edge:
  - ALU port: ex_fire & ex_wen & !ex_load & ex_rd!=0 writes ex_result.
  - Mem port: mem_wen & mem_rd!=0 writes mem_data.
  - The two ports never target the same register; the WAW stall guarantees this.
  - Writes to x0 are ignored.
- Scoreboard, per register:
  - Set on ex_fire & ex_load & ex_wen & ex_rd!=0.
  - Cleared on mem_wen for that register.
  - Set and clear on the same register in the same cycle: set wins (new load).
  - mem_wen to a non-pending register still writes the register file; the scoreboard is unchanged.
- Operand resolution for each source s (rs2 only when !id_use_imm), highest priority first:
  1. s==0 → 0.
  2. ex_fire & ex_wen & !ex_load & ex_rd==s → ex_result.
  3. mem_wen & mem_rd==s → mem_data.
  4. Otherwise the register-file value.
- When id_use_imm=1, op2 = id_imm.
- Hazard, any of the following (only for sources actually used, s≠0):
  - pending[s] & !(mem_wen & mem_rd==s);
  - ex_fire & ex_load & ex_wen & ex_rd==s (load leaving this cycle);
  - ex_valid & !ex_fire is not a hazard; the slot is simply full;
  - id_wen & id_rd≠0 & (pending[id_rd] | (ex_fire & ex_load & ex_rd==id_rd)) & !(mem_wen & mem_rd==id_rd) (WAW).
- id_ready = free & !hazard. Combinational; it may depend on ex_ready and mem_*.
- On id_fire the slot loads resolved operands and control, and ex_valid=1.
- Else if ex_fire, ex_valid=0. Else the slot holds unchanged.
- Latency: an instruction accepted in cycle N is presented as ex_valid in cycle N+1.
- Throughput: 1 per cycle with no hazards and ex_ready held 1.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release → ex_valid=0; reading x5 gives op1=0.
- Back-to-back forward (ex_ready=1 throughout):
  - Issue addi x1 (ALU returns 0x10), then add x2,x1,x1.
  - → second slot shows ex_op1=ex_op2=0x10 one cycle later.
  - Zero stall cycles.
- Load-use:
  - Issue load x3, followed immediately by add x4,x3,x0.
  - → id_ready=0 until mem_wen with mem_rd=3, mem_data=0xDEAD.
  - In that cycle id_ready=1 and ex_op1 becomes 0xDEAD.
- WAW: with x3 pending, issue addi x3 → stalled until mem_wen for x3.
  - Afterwards, the ALU write of 0x7 overwrites the register.
  - A later read of x3 gives 0x7.
- Backpressure: hold ex_ready=0 with ex_valid=1 for 4 cycles.
  - → id_ready=0 and ex_op1/ex_op2 stable.
  - Releasing ex_ready resumes 1 instruction per cycle.
- x0 handling: ALU writes 0x55 to x0, then a read of x0 → op=0; no forwarding from rd=0.
- Mid-operation reset: reset_n low while x3 is pending and the slot is full.
  - → ex_valid=0 and the scoreboard clears.
  - After release, a read of x3 does not stall.
